// File: rtl/tile_pattern_ctrl.sv
// tile_pattern_ctrl
//   Per-pixel tile lookup sequencer for color_mapper. Each cycle, the current
//   pixel coordinate is turned into a tile-map read. The returned pattern code
//   and the pixel's offset inside the tile then form a pattern-ROM read. The
//   ROM result is delivered three cycles after the pixel was presented, aligned
//   with the code and the coordinates that produced it.
//   The single-port tile map is shared with a CPU write port. The CPU gets the
//   port only during blanking. Each request is written once and acknowledged
//   once.
//
// Ports
//   Clk, Reset_n        pixel clock (rising edge); asynchronous active-low reset
//   DrawX, DrawY        current pixel coordinates from the VGA controller
//   VGA_BLANK_N         1 = visible pixel, 0 = blanking
//   map_addr/we/wdata   tile-map port (combinational)
//   map_rdata           tile-map synchronous read data (1-cycle latency)
//   pat_addr            pattern-ROM address {code, py, px} (combinational)
//   pat_rdata           pattern-ROM synchronous read data (1-cycle latency)
//   cpu_req/addr/wdata  CPU tile write request (level, held until cpu_ack)
//   cpu_ack             one-cycle write-complete pulse (registered)
//   export_pattern      pattern code for color_mapper (registered)
//   extend_color        2-bit color index for color_mapper (registered)
//   pix_valid           outputs belong to a visible pixel (registered)
//   DrawX_o, DrawY_o    coordinates aligned with the export outputs (registered)

module tile_pattern_ctrl #(
  parameter int TILE_LOG2 = 4,
  parameter int TILES_X   = 40,
  parameter int TILES_Y   = 30,
  parameter int MAP_AW    = 11
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              VGA_BLANK_N,
  output logic [MAP_AW-1:0] map_addr,
  output logic              map_we,
  output logic [7:0]        map_wdata,
  input  logic [7:0]        map_rdata,
  output logic [15:0]       pat_addr,
  input  logic [1:0]        pat_rdata,
  input  logic              cpu_req,
  input  logic [MAP_AW-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        export_pattern,
  output logic [1:0]        extend_color,
  output logic              pix_valid,
  output logic [9:0]        DrawX_o,
  output logic [9:0]        DrawY_o
);

  localparam int MAP_DEPTH = TILES_X * TILES_Y;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACK      = 2'd1;
  localparam logic [1:0] ST_WAIT_REL = 2'd2;

  // Tile coordinates of the current pixel
  logic [9:0]        tile_x;
  logic [9:0]        tile_y;
  logic [MAP_AW-1:0] disp_addr;
  logic              cpu_in_range;

  assign tile_x = DrawX >> TILE_LOG2;
  assign tile_y = DrawY >> TILE_LOG2;
  // With TILES_X = 40 the constant multiply reduces to (ty<<5)+(ty<<3)+tx.
  // The result is truncated to MAP_AW bits. In-range coordinates never reach
  // that limit, so no explicit wrap handling is needed.
  assign disp_addr    = MAP_AW'((32'(tile_y) * TILES_X) + 32'(tile_x));
  assign cpu_in_range = (32'(cpu_addr) < MAP_DEPTH);

  // FSM and pipeline registers
  logic [1:0] state_q, state_d;
  logic       cpu_ack_q, cpu_ack_d;

  logic       s1_valid_q, s1_valid_d;
  logic [9:0] s1_x_q, s1_x_d;
  logic [9:0] s1_y_q, s1_y_d;

  logic       s2_valid_q, s2_valid_d;
  logic [9:0] s2_x_q, s2_x_d;
  logic [9:0] s2_y_q, s2_y_d;
  logic [7:0] s2_code_q, s2_code_d;

  logic [7:0] export_pattern_q, export_pattern_d;
  logic [1:0] extend_color_q, extend_color_d;
  logic       pix_valid_q, pix_valid_d;
  logic [9:0] draw_x_q, draw_x_d;
  logic [9:0] draw_y_q, draw_y_d;

  // Map port arbitration and CPU handshake
  always_comb begin
    state_d  = state_q;
    map_addr = disp_addr;
    map_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Visible cycles always belong to the display. This also covers a
        // request that arrives in the same cycle blanking ends.
        if (cpu_req && !VGA_BLANK_N) begin
          map_addr = cpu_addr;
          // Out-of-range indices are acknowledged but not written, so the
          // CPU cannot stall on a bad address.
          map_we   = cpu_in_range;
          state_d  = ST_ACK;
        end
      end
      ST_ACK:      state_d = ST_WAIT_REL;
      // Hold off until the request drops, so a held request is written once.
      ST_WAIT_REL: if (!cpu_req) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // The ack flop follows the ACK state, so the pulse lasts exactly one cycle.
    cpu_ack_d = (state_d == ST_ACK);
  end

  assign map_wdata = cpu_wdata;
  // The pattern address is driven every cycle, even for blank pixels; the
  // valid bit travelling with the pixel decides whether the result is used.
  assign pat_addr  = {map_rdata, s1_y_q[TILE_LOG2-1:0], s1_x_q[TILE_LOG2-1:0]};

  // Three-stage display pipe; it never stalls
  always_comb begin
    s1_valid_d = VGA_BLANK_N;
    s1_x_d     = DrawX;
    s1_y_d     = DrawY;

    s2_valid_d = s1_valid_q;
    s2_x_d     = s1_x_q;
    s2_y_d     = s1_y_q;
    s2_code_d  = map_rdata;

    pix_valid_d      = s2_valid_q;
    draw_x_d         = s2_x_q;
    draw_y_d         = s2_y_q;
    export_pattern_d = s2_valid_q ? s2_code_q : 8'd0;
    extend_color_d   = s2_valid_q ? pat_rdata : 2'd0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q          <= ST_IDLE;
      cpu_ack_q        <= 1'b0;
      s1_valid_q       <= 1'b0;
      s1_x_q           <= '0;
      s1_y_q           <= '0;
      s2_valid_q       <= 1'b0;
      s2_x_q           <= '0;
      s2_y_q           <= '0;
      s2_code_q        <= '0;
      export_pattern_q <= '0;
      extend_color_q   <= '0;
      pix_valid_q      <= 1'b0;
      draw_x_q         <= '0;
      draw_y_q         <= '0;
    end else begin
      state_q          <= state_d;
      cpu_ack_q        <= cpu_ack_d;
      s1_valid_q       <= s1_valid_d;
      s1_x_q           <= s1_x_d;
      s1_y_q           <= s1_y_d;
      s2_valid_q       <= s2_valid_d;
      s2_x_q           <= s2_x_d;
      s2_y_q           <= s2_y_d;
      s2_code_q        <= s2_code_d;
      export_pattern_q <= export_pattern_d;
      extend_color_q   <= extend_color_d;
      pix_valid_q      <= pix_valid_d;
      draw_x_q         <= draw_x_d;
      draw_y_q         <= draw_y_d;
    end
  end

  assign cpu_ack        = cpu_ack_q;
  assign export_pattern = export_pattern_q;
  assign extend_color   = extend_color_q;
  assign pix_valid      = pix_valid_q;
  assign DrawX_o        = draw_x_q;
  assign DrawY_o        = draw_y_q;

endmodule

// File: tb/tb_tile_pattern_ctrl.sv
// tb_tile_pattern_ctrl
//   Directed bench for tile_pattern_ctrl. It models the tile map as a
//   synchronous RAM and the pattern ROM as a synchronous lookup of a few known
//   entries. A table of pixels is streamed through the pipe. Hand-written
//   sequences cover reset and the CPU write handshake.

module tb_tile_pattern_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        VGA_BLANK_N;
  logic [10:0] map_addr;
  logic        map_we;
  logic [7:0]  map_wdata;
  logic [7:0]  map_rdata;
  logic [15:0] pat_addr;
  logic [1:0]  pat_rdata;
  logic        cpu_req;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  export_pattern;
  logic [1:0]  extend_color;
  logic        pix_valid;
  logic [9:0]  DrawX_o, DrawY_o;

  int checks   = 0;
  int failures = 0;

  // Preload path into the map model, used only while the design is in reset
  logic        pre_we;
  logic [10:0] pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  map_mem [0:2047];

  always #5 Clk = ~Clk;

  tile_pattern_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .VGA_BLANK_N(VGA_BLANK_N), .map_addr(map_addr), .map_we(map_we),
    .map_wdata(map_wdata), .map_rdata(map_rdata), .pat_addr(pat_addr),
    .pat_rdata(pat_rdata), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .export_pattern(export_pattern),
    .extend_color(extend_color), .pix_valid(pix_valid), .DrawX_o(DrawX_o),
    .DrawY_o(DrawY_o)
  );

  function automatic logic [1:0] rom_f(input logic [15:0] a);
    case (a)
      16'h0532: rom_f = 2'b10;
      16'h77FF: rom_f = 2'b01;
      16'h1100: rom_f = 2'b11;
      16'hC324: rom_f = 2'b01;
      16'h0000: rom_f = 2'b10;
      16'h0501: rom_f = 2'b11;
      16'hAA00: rom_f = 2'b01;
      default:  rom_f = 2'b00;
    endcase
  endfunction

  always @(posedge Clk) begin
    if (pre_we)      map_mem[pre_addr] <= pre_data;
    else if (map_we) map_mem[map_addr] <= map_wdata;
    map_rdata <= map_mem[map_addr];
    pat_rdata <= rom_f(pat_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, input logic vis);
    DrawX = x;
    DrawY = y;
    VGA_BLANK_N = vis;
  endtask

  task automatic chk_out_zero(input string tag);
    chk({tag, "_export"}, 32'(export_pattern), 32'd0);
    chk({tag, "_color"},  32'(extend_color),   32'd0);
    chk({tag, "_valid"},  32'(pix_valid),      32'd0);
    chk({tag, "_xo"},     32'(DrawX_o),        32'd0);
    chk({tag, "_yo"},     32'(DrawY_o),        32'd0);
    chk({tag, "_ack"},    32'(cpu_ack),        32'd0);
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vis;
    logic [10:0] exp_addr;
    logic [7:0]  exp_code;
    logic [1:0]  exp_color;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
  } pre_t;
  pre_t pre [6];

  initial begin
    int we_cnt;
    int ack_cnt;

    // Pixel vectors: expected map index and code/colour derived by hand
    // from the preload list and rom_f
    vecs[0] = '{10'd18,  10'd19,  1'b1, 11'd41,   8'h05, 2'b10};
    vecs[1] = '{10'd639, 10'd479, 1'b1, 11'd1199, 8'h77, 2'b01};
    vecs[2] = '{10'd0,   10'd0,   1'b1, 11'd0,    8'h11, 2'b11};
    vecs[3] = '{10'd5,   10'd300, 1'b0, 11'd720,  8'h00, 2'b00};
    vecs[4] = '{10'd100, 10'd50,  1'b1, 11'd126,  8'hC3, 2'b01};
    vecs[5] = '{10'd639, 10'd479, 1'b0, 11'd1199, 8'h00, 2'b00};
    vecs[6] = '{10'd320, 10'd240, 1'b1, 11'd620,  8'h00, 2'b10};
    vecs[7] = '{10'd17,  10'd16,  1'b1, 11'd41,   8'h05, 2'b11};

    pre[0] = '{11'd41,   8'h05};
    pre[1] = '{11'd1199, 8'h77};
    pre[2] = '{11'd0,    8'h11};
    pre[3] = '{11'd126,  8'hC3};
    pre[4] = '{11'd620,  8'h00};
    pre[5] = '{11'd7,    8'h00};

    Reset_n = 1'b0;
    drive_pix(10'd0, 10'd0, 1'b0);
    cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    // Preload the map while the design is held in reset
    for (int i = 0; i < 6; i++) begin
      pre_we = 1'b1; pre_addr = pre[i].addr; pre_data = pre[i].data;
      tick();
    end
    pre_we = 1'b0;
    tick();
    chk_out_zero("reset");
    chk("reset_map_we", 32'(map_we), 32'd0);
    Reset_n = 1'b1;

    // Stream the table: in cycle i, outputs belong to the pixel of cycle i-3
    for (int i = 0; i < NVEC + 3; i++) begin
      tick();
      if (i < NVEC) drive_pix(vecs[i].x, vecs[i].y, vecs[i].vis);
      else          drive_pix(10'd0, 10'd0, 1'b0);
      #1;
      if (i < NVEC) begin
        chk($sformatf("v%0d_map_addr", i), 32'(map_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("v%0d_map_we", i), 32'(map_we), 32'd0);
      end
      if (i >= 1 && i <= NVEC && vecs[i-1].vis)
        chk($sformatf("v%0d_pat_addr", i-1), 32'(pat_addr),
            32'({vecs[i-1].exp_code, vecs[i-1].y[3:0], vecs[i-1].x[3:0]}));
      if (i >= 3) begin
        chk($sformatf("v%0d_valid", i-3),  32'(pix_valid),      32'(vecs[i-3].vis));
        chk($sformatf("v%0d_export", i-3), 32'(export_pattern), 32'(vecs[i-3].exp_code));
        chk($sformatf("v%0d_color", i-3),  32'(extend_color),   32'(vecs[i-3].exp_color));
        chk($sformatf("v%0d_xo", i-3),     32'(DrawX_o),        32'(vecs[i-3].x));
        chk($sformatf("v%0d_yo", i-3),     32'(DrawY_o),        32'(vecs[i-3].y));
        $display("pixel x=%0d y=%0d vis=%0d -> code=%0h color=%0d valid=%0d",
                 vecs[i-3].x, vecs[i-3].y, vecs[i-3].vis, export_pattern, extend_color, pix_valid);
      end
    end

    // Mid-frame asynchronous reset, then restart latency
    tick(); drive_pix(10'd18, 10'd19, 1'b1);
    tick(); drive_pix(10'd0, 10'd0, 1'b0);
    tick();
    tick();
    chk("pre_rst_valid", 32'(pix_valid), 32'd1);
    #1 Reset_n = 1'b0;
    #1 chk_out_zero("async_rst");
    #1 Reset_n = 1'b1;
    tick(); drive_pix(10'd18, 10'd19, 1'b1);
    tick(); drive_pix(10'd0, 10'd0, 1'b0);
    chk("restart_c1_valid", 32'(pix_valid), 32'd0);
    tick();
    chk("restart_c2_valid", 32'(pix_valid), 32'd0);
    tick();
    chk("restart_c3_valid",  32'(pix_valid),      32'd1);
    chk("restart_c3_export", 32'(export_pattern), 32'h05);
    chk("restart_c3_color",  32'(extend_color),   32'd2);
    $display("reset: first valid pixel after restart code=%0h", export_pattern);

    // CPU write held off through visible cycles, including one where the
    // request and visibility start together
    tick();
    cpu_req = 1'b1; cpu_addr = 11'd7; cpu_wdata = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      drive_pix(10'd18, 10'd19, 1'b1);
      #1;
      chk($sformatf("cpu_vis%0d_we", k),   32'(map_we),   32'd0);
      chk($sformatf("cpu_vis%0d_addr", k), 32'(map_addr), 32'd41);
      tick();
    end
    drive_pix(10'd0, 10'd0, 1'b0);
    #1;
    chk("cpu_blank_we",    32'(map_we),    32'd1);
    chk("cpu_blank_addr",  32'(map_addr),  32'd7);
    chk("cpu_blank_wdata", 32'(map_wdata), 32'hAA);
    chk("cpu_blank_ack",   32'(cpu_ack),   32'd0);
    tick();
    chk("cpu_ack_pulse", 32'(cpu_ack), 32'd1);
    chk("cpu_ack_we",    32'(map_we),   32'd0);
    tick();
    chk("cpu_ack_drop",  32'(cpu_ack), 32'd0);
    cpu_req = 1'b0;
    tick();
    $display("cpu write addr=7 data=aa acknowledged");

    // Read tile 7 back through the display pipe
    tick(); drive_pix(10'd112, 10'd0, 1'b1);
    tick(); drive_pix(10'd0, 10'd0, 1'b0);
    tick();
    tick();
    chk("rb_valid",  32'(pix_valid),      32'd1);
    chk("rb_export", 32'(export_pattern), 32'hAA);
    chk("rb_color",  32'(extend_color),   32'd1);
    $display("readback tile 7 code=%0h", export_pattern);

    // Request held high long after the ack: one write, one ack
    tick();
    cpu_req = 1'b1; cpu_addr = 11'd620; cpu_wdata = 8'h5A;
    we_cnt = 0; ack_cnt = 0;
    for (int k = 0; k < 24; k++) begin
      if (k == 22) cpu_req = 1'b0;
      #1;
      we_cnt  += int'(map_we);
      ack_cnt += int'(cpu_ack);
      tick();
    end
    chk("held_we_count",  32'(we_cnt),  32'd1);
    chk("held_ack_count", 32'(ack_cnt), 32'd1);
    $display("held request: writes=%0d acks=%0d", we_cnt, ack_cnt);

    // Out-of-range index: acknowledged, never written
    cpu_req = 1'b1; cpu_addr = 11'd1500; cpu_wdata = 8'h33;
    we_cnt = 0; ack_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) cpu_req = 1'b0;
      #1;
      we_cnt  += int'(map_we);
      ack_cnt += int'(cpu_ack);
      tick();
    end
    chk("oor_we_count",  32'(we_cnt),  32'd0);
    chk("oor_ack_count", 32'(ack_cnt), 32'd1);
    $display("out-of-range request: writes=%0d acks=%0d", we_cnt, ack_cnt);

    // Reset while in ACK drops the ack and forgets the request
    cpu_req = 1'b1; cpu_addr = 11'd126; cpu_wdata = 8'hC3;
    #1;
    chk("rst_ack_we", 32'(map_we), 32'd1);
    tick();
    chk("rst_ack_pre", 32'(cpu_ack), 32'd1);
    #1 Reset_n = 1'b0; cpu_req = 1'b0;
    #1 chk("rst_ack_cleared", 32'(cpu_ack), 32'd0);
    #1 Reset_n = 1'b1;
    tick();
    chk("rst_ack_idle_ack", 32'(cpu_ack), 32'd0);
    chk("rst_ack_idle_we",  32'(map_we),  32'd0);
    $display("reset during ack: ack cleared");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
